adc_avg_ctrl: RTL and testbench

- Sequences the 8-bit parallel ADC front end of the digital voltmeter.
- Generates ad_clk and captures ad_data once per ad_clk period.
- Averages a block of 2^AVG_LOG2 samples and scales the mean to millivolts.
- Hands the result to the display/segment stage over a valid/ready handshake, holding off further conversions until the display accepts the value.

---
 rtl/adc_avg_ctrl.sv | 129 ++++++++++++
 tb/tb_adc_avg_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_ctrl.sv
// Sequences an 8-bit parallel ADC: generates ad_clk, averages 2^AVG_LOG2 captures,
// scales the mean to millivolts and offers it to the display over valid/ready.
`timescale 1ns/1ps
module adc_avg_ctrl #(
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned VREF_MV  = 5000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [7:0]  ad_data,
  input  logic        volt_rdy,
  output logic        ad_clk,
  output logic [15:0] volt_mv,
  output logic        volt_vld,
  output logic        busy
);

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned VOLT_W     = 16;
  localparam int unsigned DIV_PERIOD = 2 * CLK_DIV;
  localparam int unsigned DIV_W      = (DIV_PERIOD > 1) ? $clog2(DIV_PERIOD) : 1;
  localparam int unsigned ACC_W      = DATA_W + AVG_LOG2;
  localparam int unsigned SMP_W      = AVG_LOG2 + 1;
  localparam int unsigned N_SMP      = 1 << AVG_LOG2;
  localparam int unsigned VREF_W     = $clog2(VREF_MV + 1);
  localparam int unsigned PROD_W     = (DATA_W + VREF_W > 24) ? (DATA_W + VREF_W) : 24;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(N_SMP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CALC,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SMP_W-1:0]    smp_q, smp_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ad_clk_q, ad_clk_d;
  logic [VOLT_W-1:0]   volt_q, volt_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   avg_c;
  logic [PROD_W-1:0]   prod_c;

  // Mean of the block and its millivolt scaling; acc has headroom for N full-scale codes.
  assign avg_c  = DATA_W'(acc_q >> AVG_LOG2);
  assign prod_c = PROD_W'(avg_c) * PROD_W'(VREF_MV);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      smp_q    <= '0;
      acc_q    <= '0;
      ad_clk_q <= 1'b0;
      volt_q   <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      smp_q    <= smp_d;
      acc_q    <= acc_d;
      ad_clk_q <= ad_clk_d;
      volt_q   <= volt_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
    end
  end

  // Counters and accumulator are only live in SAMPLE; every other state parks them at zero.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    smp_d   = '0;
    acc_d   = '0;
    volt_d  = volt_q;
    vld_d   = vld_q;

    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        div_d = div_q;
        smp_d = smp_q;
        acc_d = acc_q;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          acc_d = acc_q + ACC_W'(ad_data);
          smp_d = smp_q + SMP_W'(1);
          if (smp_q == SMP_LAST) state_d = S_CALC;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_CALC: begin
        volt_d  = VOLT_W'(prod_c >> 8);
        vld_d   = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (volt_rdy) begin
          vld_d   = 1'b0;
          state_d = en ? S_SAMPLE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ad_clk is high for the first CLK_DIV counts of each conversion period.
    ad_clk_d = (state_d == S_SAMPLE) && (div_d < DIV_HIGH);
    busy_d   = (state_d != S_IDLE);
  end

  assign ad_clk   = ad_clk_q;
  assign volt_mv  = volt_q;
  assign volt_vld = vld_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_adc_avg_ctrl.sv
// Bench for adc_avg_ctrl: table-driven blocks, randomized blocks against an arithmetic
// model, plus hand-written en-drop and mid-block reset sequences.
`timescale 1ns/1ps
module tb_adc_avg_ctrl;

  localparam int CD   = 25;
  localparam int L2   = 3;
  localparam int N    = 1 << L2;
  localparam int P    = 2 * CD;
  localparam int VREF = 5000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        en;
  logic [7:0]  ad_data;
  logic        volt_rdy;
  logic        ad_clk;
  logic [15:0] volt_mv;
  logic        volt_vld;
  logic        busy;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_v;

  typedef struct {
    logic [63:0] s;
    int          hold;
    bit          en_next;
    int          exp_v;
  } vec_t;

  vec_t vt [4];

  adc_avg_ctrl #(.CLK_DIV(CD), .AVG_LOG2(L2), .VREF_MV(VREF)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .ad_data (ad_data),
    .volt_rdy(volt_rdy),
    .ad_clk  (ad_clk),
    .volt_mv (volt_mv),
    .volt_vld(volt_vld),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference: mean of the N captures, truncated, scaled by VREF/256, truncated.
  function automatic int model_volt(input logic [63:0] s);
    int sum;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(s[i*8 +: 8]);
    return ((sum / N) * VREF) / 256;
  endfunction

  // Called one step after the edge that starts SAMPLE; the correct code is only
  // presented in the cycle right before each expected capture edge.
  task automatic sample_block(input logic [63:0] s, input int drop_t, input int exp_v);
    int errs;
    errs = 0;
    for (int t = 0; t < N * P; t++) begin
      if (t % P == 0) ad_data = 8'($urandom);
      if (t % P == P - 1) ad_data = s[(t / P) * 8 +: 8];
      if (t == drop_t) en = 1'b0;
      volt_rdy = 1'($urandom);
      if (ad_clk !== 1'((t % P) < CD)) errs++;
      if (busy !== 1'b1) errs++;
      if (volt_vld !== 1'b0) errs++;
      if (volt_mv !== last_v) errs++;
      tick();
    end
    chk("sample_phase_errs", errs, 0);
    chk("calc_vld_low", volt_vld, 0);
    chk("calc_adclk_low", ad_clk, 0);
    tick();
    chk("vld_latency", volt_vld, 1);
    chk("volt_mv", volt_mv, exp_v);
    chk("hold_adclk_low", ad_clk, 0);
    last_v = 16'(exp_v);
  endtask

  task automatic hold_phase(input int hold, input bit en_next);
    int errs;
    errs = 0;
    volt_rdy = 1'b0;
    repeat (hold) begin
      tick();
      if (volt_vld !== 1'b1 || volt_mv !== last_v || ad_clk !== 1'b0 || busy !== 1'b1) errs++;
    end
    chk("hold_stable_errs", errs, 0);
    en       = en_next;
    volt_rdy = 1'b1;
    tick();
    volt_rdy = 1'b0;
    chk("rdy_vld_drop", volt_vld, 0);
    chk("busy_after_rdy", busy, en_next);
    chk("adclk_after_rdy", ad_clk, en_next);
    chk("volt_retained", volt_mv, last_v);
  endtask

  task automatic idle_check(input int cycles);
    int errs;
    errs = 0;
    repeat (cycles) begin
      ad_data  = 8'($urandom);
      volt_rdy = 1'($urandom);
      tick();
      if (busy !== 1'b0 || ad_clk !== 1'b0 || volt_vld !== 1'b0 || volt_mv !== last_v) errs++;
    end
    chk("idle_errs", errs, 0);
  endtask

  initial begin
    bit          in_idle;
    logic [63:0] rs;
    int          rh;
    bit          ren;

    vt[0] = '{s: {8{8'd125}}, hold: 0,    en_next: 1'b1, exp_v: 2441};
    vt[1] = '{s: {8{8'd255}}, hold: 3,    en_next: 1'b1, exp_v: 4980};
    vt[2] = '{s: {8{8'd0}},   hold: 0,    en_next: 1'b1, exp_v: 0};
    vt[3] = '{s: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
              hold: 1000, en_next: 1'b0, exp_v: 58};

    en       = 1'b0;
    ad_data  = 8'd0;
    volt_rdy = 1'b0;
    last_v   = 16'd0;

    #1 sys_rst = 1'b1;
    #1;
    chk("rst_adclk", ad_clk, 0);
    chk("rst_volt", volt_mv, 0);
    chk("rst_vld", volt_vld, 0);
    chk("rst_busy", busy, 0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    idle_check(5);

    in_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (in_idle) begin
        en = 1'b1;
        tick();
      end
      sample_block(vt[i].s, -1, vt[i].exp_v);
      hold_phase(vt[i].hold, vt[i].en_next);
      in_idle = !vt[i].en_next;
      if (in_idle) idle_check(10);
    end

    for (int r = 0; r < 6; r++) begin
      rs  = {$urandom, $urandom};
      rh  = int'($urandom_range(0, 20));
      ren = (r == 5) ? 1'b0 : 1'($urandom);
      if (in_idle) begin
        en = 1'b1;
        tick();
      end
      sample_block(rs, -1, model_volt(rs));
      hold_phase(rh, ren);
      in_idle = !ren;
      if (in_idle) idle_check(4);
    end

    // en falls after the third capture; the block must still run to completion.
    en = 1'b1;
    tick();
    sample_block({8{8'd100}}, 3 * P + 5, model_volt({8{8'd100}}));
    hold_phase(2, 1'b0);
    idle_check(10);

    // Reset in the middle of a block, released with en held high.
    en = 1'b1;
    tick();
    repeat (130) begin
      ad_data = 8'd200;
      tick();
    end
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_adclk", ad_clk, 0);
    chk("midrst_volt", volt_mv, 0);
    chk("midrst_vld", volt_vld, 0);
    chk("midrst_busy", busy, 0);
    last_v = 16'd0;
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    tick();
    sample_block({8{8'd10}}, -1, model_volt({8{8'd10}}));
    hold_phase(0, 1'b0);
    idle_check(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
